// File: rtl/disp_pkg.sv
// Shared digit indices, segment constants and snapshot payload for the
// six-digit BCD scan display.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned NUM_BCD    = 10;

  typedef logic [IDX_W-1:0] digit_idx_t;

  localparam digit_idx_t SLOT_S0 = 3'd0;
  localparam digit_idx_t SLOT_S1 = 3'd1;
  localparam digit_idx_t SLOT_M0 = 3'd2;
  localparam digit_idx_t SLOT_M1 = 3'd3;
  localparam digit_idx_t SLOT_H0 = 3'd4;
  localparam digit_idx_t SLOT_H1 = 3'd5;

  // Active-low {g,f,e,d,c,b,a}: everything off, and the dash for invalid BCD.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;

  // Active-high gfedcba encodings for digits 0..9.
  localparam logic [SEG_W-1:0] SEG_TABLE [NUM_BCD] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  typedef struct packed {
    logic [DIGIT_W-1:0] h1;
    logic [DIGIT_W-1:0] h0;
    logic [DIGIT_W-1:0] m1;
    logic [DIGIT_W-1:0] m0;
    logic [DIGIT_W-1:0] s1;
    logic [DIGIT_W-1:0] s0;
  } digits_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; codes 10..15
// render as a dash.
module bcd_to_seg7
  import disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_bcd,
  output logic [SEG_W-1:0]   o_seg_n_c
);

  always_comb begin
    o_seg_n_c = SEG_DASH;
    if (i_bcd < DIGIT_W'(NUM_BCD)) begin
      o_seg_n_c = ~SEG_TABLE[i_bcd];
    end
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Six-digit multiplexed common-anode display driver with per-frame snapshot
// and per-slot blanking. Define DISP_LZ_BLANK_EN to blank a leading zero on h1.
module bcd_scan_display
  import disp_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES  = 8333,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [DIGIT_W-1:0]    display_h1_export,
  input  logic [DIGIT_W-1:0]    display_h0_export,
  input  logic [DIGIT_W-1:0]    display_m1_export,
  input  logic [DIGIT_W-1:0]    display_m0_export,
  input  logic [DIGIT_W-1:0]    display_s1_export,
  input  logic [DIGIT_W-1:0]    display_s0_export,
  input  logic                  colon_on,
  output logic [SEG_W-1:0]      seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_start
);

  localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  logic [CNT_W-1:0]      r_slot_cnt;
  digit_idx_t            r_idx;
  digits_t               r_snap;
  logic [SEG_W-1:0]      r_seg_n;
  logic                  r_dp_n;
  logic [NUM_DIGITS-1:0] r_an_n;
  logic                  r_frame_start;

  logic [CNT_W-1:0]      w_slot_cnt_nxt;
  digit_idx_t            w_idx_nxt;
  digits_t               w_inputs;
  digits_t               w_snap_nxt;
  logic                  w_wrap;
  logic                  w_snap_take;
  logic                  w_drive_nxt;
  logic                  w_lz_blank;
  logic [DIGIT_W-1:0]    w_digit;
  logic [SEG_W-1:0]      w_dec_seg_n;
  logic [SEG_W-1:0]      w_seg_n_nxt;
  logic                  w_dp_n_nxt;
  logic [NUM_DIGITS-1:0] w_an_n_nxt;

  assign w_inputs = '{h1: display_h1_export, h0: display_h0_export,
                      m1: display_m1_export, m0: display_m0_export,
                      s1: display_s1_export, s0: display_s0_export};

  // Slot timing and frame snapshot.
  always_comb begin
    w_wrap         = (r_slot_cnt == CNT_W'(SLOT_CYCLES - 1));
    w_slot_cnt_nxt = w_wrap ? '0 : r_slot_cnt + CNT_W'(1);
    w_idx_nxt      = r_idx;
    if (w_wrap) begin
      w_idx_nxt = (r_idx == SLOT_H1) ? SLOT_S0 : r_idx + IDX_W'(1);
    end
    w_snap_take = (r_slot_cnt == '0) && (r_idx == SLOT_S0);
    w_snap_nxt  = w_snap_take ? w_inputs : r_snap;
    w_drive_nxt = (w_slot_cnt_nxt >= CNT_W'(BLANK_CYCLES));
  end

  // Outputs are computed for the upcoming slot position so they land on the
  // same edge that moves the counter into that phase.
  always_comb begin
    w_digit = '0;
    case (w_idx_nxt)
      SLOT_S0: w_digit = w_snap_nxt.s0;
      SLOT_S1: w_digit = w_snap_nxt.s1;
      SLOT_M0: w_digit = w_snap_nxt.m0;
      SLOT_M1: w_digit = w_snap_nxt.m1;
      SLOT_H0: w_digit = w_snap_nxt.h0;
      SLOT_H1: w_digit = w_snap_nxt.h1;
      default: w_digit = '0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .i_bcd     (w_digit),
    .o_seg_n_c (w_dec_seg_n)
  );

`ifdef DISP_LZ_BLANK_EN
  assign w_lz_blank = (w_idx_nxt == SLOT_H1) && (w_snap_nxt.h1 == '0);
`else
  assign w_lz_blank = 1'b0;
`endif

  always_comb begin
    w_an_n_nxt  = '1;
    w_seg_n_nxt = SEG_BLANK;
    w_dp_n_nxt  = 1'b1;
    if (w_drive_nxt) begin
      w_an_n_nxt  = ~(NUM_DIGITS'(1) << w_idx_nxt);
      w_seg_n_nxt = w_lz_blank ? SEG_BLANK : w_dec_seg_n;
      w_dp_n_nxt  = ~(colon_on && !w_lz_blank &&
                      ((w_idx_nxt == SLOT_M0) || (w_idx_nxt == SLOT_H0)));
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_slot_cnt    <= '0;
      r_idx         <= SLOT_S0;
      r_snap        <= '0;
      r_an_n        <= '1;
      r_seg_n       <= SEG_BLANK;
      r_dp_n        <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_slot_cnt    <= w_slot_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_snap        <= w_snap_nxt;
      r_an_n        <= w_an_n_nxt;
      r_seg_n       <= w_seg_n_nxt;
      r_dp_n        <= w_dp_n_nxt;
      r_frame_start <= w_snap_take;
    end
  end

  assign seg_n       = r_seg_n;
  assign dp_n        = r_dp_n;
  assign an_n        = r_an_n;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with 20-cycle slots and 4-cycle blanking.
module tb_bcd_scan_display;

  localparam int unsigned SLOT  = 20;
  localparam int unsigned BLANK = 4;
  localparam int unsigned FRAME = 6 * SLOT;

  logic       clk;
  logic       rst_n;
  logic [3:0] h1, h0, m1, m0, s1, s0;
  logic       colon;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] an_n;
  logic       frame_start;

  int n_pass  = 0;
  int n_total = 0;

  logic [6:0] exp_seg_n [6];
  logic       colon_at_edge;

  bcd_scan_display #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk_clk           (clk),
    .reset_reset_n     (rst_n),
    .display_h1_export (h1),
    .display_h0_export (h0),
    .display_m1_export (m1),
    .display_m0_export (m0),
    .display_s1_export (s1),
    .display_s0_export (s0),
    .colon_on          (colon),
    .seg_n             (seg_n),
    .dp_n              (dp_n),
    .an_n              (an_n),
    .frame_start       (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, exp);
  endtask

  // Expected {an_n, seg_n, dp_n, frame_start} at cycle c of a run since reset.
  function automatic logic [14:0] expect_at(input int c, input logic col);
    int         slot;
    int         cnt;
    logic       drive;
    logic [5:0] one;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fs;
    one   = 6'b000001;
    slot  = (c / SLOT) % 6;
    cnt   = c % SLOT;
    drive = (cnt >= BLANK);
    e_an  = drive ? ~(one << slot) : 6'h3F;
    e_seg = drive ? exp_seg_n[slot] : 7'h7F;
    e_dp  = !(drive && col && (slot == 2 || slot == 4));
    e_fs  = ((c % FRAME) == 1);
    return {e_an, e_seg, e_dp, e_fs};
  endfunction

  task automatic tick();
    colon_at_edge = colon;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    colon = 1'b0;
    colon_at_edge = 1'b0;
    h1 = 4'd1; h0 = 4'd2; m1 = 4'd3; m0 = 4'd4; s1 = 4'd5; s0 = 4'd6;
    // Frame 0 digits, slot order s0..h1: 6,5,4,3,2,1.
    exp_seg_n[0] = ~7'h7D; exp_seg_n[1] = ~7'h6D; exp_seg_n[2] = ~7'h66;
    exp_seg_n[3] = ~7'h4F; exp_seg_n[4] = ~7'h5B; exp_seg_n[5] = ~7'h06;

    #23;
    chk("rst_an",  0, 32'(an_n),        32'h3F);
    chk("rst_seg", 0, 32'(seg_n),       32'h7F);
    chk("rst_dp",  0, 32'(dp_n),        32'h1);
    chk("rst_fs",  0, 32'(frame_start), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Two full frames plus part of a third, up to mid-drive of slot 3.
    for (int c = 0; c <= 2 * FRAME + 3 * SLOT + 5; c++) begin
      if (c == FRAME) begin
        exp_seg_n[0] = ~7'h6F;
        exp_seg_n[4] = ~7'h40;
      end
      chk("scan", c, 32'({an_n, seg_n, dp_n, frame_start}),
          32'(expect_at(c, colon_at_edge)));
      if (c == 2 * SLOT + 5) begin
        s0 = 4'd9;
        h0 = 4'hC;
      end
      if (c == FRAME) colon = 1'b1;
      if (c == FRAME + 4 * SLOT + 10) colon = 1'b0;
      if (c == FRAME + 10) h1 = 4'd0;
      if (c == 2 * FRAME + 3 * SLOT + 5) break;
      tick();
    end

    // Asynchronous reset mid-drive of slot 3, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an",  0, 32'(an_n),        32'h3F);
    chk("arst_seg", 0, 32'(seg_n),       32'h7F);
    chk("arst_dp",  0, 32'(dp_n),        32'h1);
    chk("arst_fs",  0, 32'(frame_start), 32'h0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    colon = 1'b0;
    colon_at_edge = 1'b0;
    #1;

    // Fresh snapshot: s0=9, s1=5, m0=4, m1=3, h0=C (dash), h1=0.
    exp_seg_n[0] = ~7'h6F; exp_seg_n[1] = ~7'h6D; exp_seg_n[2] = ~7'h66;
    exp_seg_n[3] = ~7'h4F; exp_seg_n[4] = ~7'h40;
`ifdef DISP_LZ_BLANK_EN
    exp_seg_n[5] = 7'h7F;
`else
    exp_seg_n[5] = ~7'h3F;
`endif

    for (int c = 0; c <= FRAME + 5; c++) begin
      chk("scan2", c, 32'({an_n, seg_n, dp_n, frame_start}),
          32'(expect_at(c, colon_at_edge)));
      if (c == FRAME + 5) break;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
